// File: rtl/xc_malu_pkg.sv
// Shared constants for the MALU packed-multiply sequencer: FSM encoding,
// pack-width one-hot bit positions, lane widths and the iteration guard.
package xc_malu_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // Bit positions inside the one-hot {pw_16,pw_8,pw_4,pw_2} field
  localparam int PW_2  = 0;
  localparam int PW_4  = 1;
  localparam int PW_8  = 2;
  localparam int PW_16 = 3;

  localparam logic [5:0] W_16 = 6'd16;
  localparam logic [5:0] W_8  = 6'd8;
  localparam logic [5:0] W_4  = 6'd4;
  localparam logic [5:0] W_2  = 6'd2;

  localparam logic [5:0] COUNT_MAX = 6'd63;

endpackage

// File: rtl/xc_malu_pw_decode.sv
// Pack-width decode: one-hot legality check and lane width in bits.
module xc_malu_pw_decode
  import xc_malu_pkg::*;
(
  input  logic [3:0] pw,
  output logic       legal,
  output logic [5:0] width
);

  always_comb begin
    legal = (pw != 4'd0) && ((pw & (pw - 4'd1)) == 4'd0);
    width = 6'd0;
    if (legal) begin
      if (pw[PW_16])     width = W_16;
      else if (pw[PW_8]) width = W_8;
      else if (pw[PW_4]) width = W_4;
      else               width = W_2;
    end
  end

endmodule

// File: rtl/xc_malu_pmul_seq.sv
// Iterative sequencer for pmul/pmulh: owns acc/arg_0/count around an external
// combinational step. Optional XC_MALU_PMUL_SEQ_ZERO_SKIP_EN short-circuits zero operands.
module xc_malu_pmul_seq
  import xc_malu_pkg::*;
#(
  parameter int XLEN = 32,
  parameter int ACCW = 64
) (
  input  logic            g_clk,
  input  logic            g_reset,
  input  logic            flush,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic [XLEN-1:0] req_rs1,
  input  logic [XLEN-1:0] req_rs2,
  input  logic            req_high,
  input  logic            req_clmul,
  input  logic [3:0]      req_pw,
  output logic [XLEN-1:0] step_rs1,
  output logic [ACCW-1:0] step_acc,
  output logic [XLEN-1:0] step_arg_0,
  output logic [5:0]      step_count,
  output logic            step_carryless,
  output logic [3:0]      step_pw,
  input  logic [ACCW-1:0] step_n_acc,
  input  logic [XLEN-1:0] step_n_arg_0,
  input  logic [ACCW-1:0] step_result,
  input  logic            step_ready,
  output logic            rsp_valid,
  input  logic            rsp_ack,
  output logic [XLEN-1:0] rsp_rd,
  output logic            busy
);

  state_t          state, state_nxt;
  logic [XLEN-1:0] rs1_q, arg_0_q, rd_q;
  logic [ACCW-1:0] acc_q;
  logic [5:0]      count_q;
  logic [3:0]      pw_q, pw_sel;
  logic            high_q, clmul_q;
  logic            pw_legal, skip, cnt_max;
  logic [5:0]      pw_width;

  // One decoder serves both the incoming request (IDLE) and the latched width (RUN)
  assign pw_sel  = (state == ST_IDLE) ? req_pw : pw_q;
  assign cnt_max = (count_q == COUNT_MAX);

  xc_malu_pw_decode u_pw_decode (
    .pw    (pw_sel),
    .legal (pw_legal),
    .width (pw_width)
  );

`ifdef XC_MALU_PMUL_SEQ_ZERO_SKIP_EN
  assign skip = (req_rs1 == '0) || (req_rs2 == '0);
`else
  assign skip = 1'b0;
`endif

  always_ff @(posedge g_clk or posedge g_reset) begin
    if (g_reset) state <= ST_IDLE;
    else         state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (flush) state_nxt = ST_IDLE;
    else begin
      unique case (state)
        ST_IDLE: if (req_valid) state_nxt = (!pw_legal || skip) ? ST_DONE : ST_RUN;
        ST_RUN:  if (step_ready || cnt_max) state_nxt = ST_DONE;
        ST_DONE: if (rsp_ack) state_nxt = ST_IDLE;
        default: state_nxt = ST_IDLE;
      endcase
    end
  end

  always_comb begin
    req_ready = (state == ST_IDLE);
    rsp_valid = (state == ST_DONE);
    busy      = (state != ST_IDLE);
  end

  // Datapath holds its values across flush; only the FSM is aborted
  always_ff @(posedge g_clk or posedge g_reset) begin
    if (g_reset) begin
      rs1_q   <= '0;
      arg_0_q <= '0;
      acc_q   <= '0;
      count_q <= '0;
      pw_q    <= '0;
      high_q  <= 1'b0;
      clmul_q <= 1'b0;
      rd_q    <= '0;
    end else if (!flush) begin
      if (state == ST_IDLE && req_valid) begin
        rs1_q   <= req_rs1;
        high_q  <= req_high;
        clmul_q <= req_clmul;
        pw_q    <= req_pw;
        acc_q   <= '0;
        arg_0_q <= req_rs2;
        count_q <= '0;
        if (!pw_legal || skip) rd_q <= '0;
      end else if (state == ST_RUN) begin
        if (step_ready)   rd_q <= high_q ? step_result[ACCW-1:XLEN] : step_result[XLEN-1:0];
        else if (cnt_max) rd_q <= '0;
        else begin
          acc_q   <= step_n_acc;
          arg_0_q <= step_n_arg_0;
          count_q <= count_q + 6'd1;
        end
      end
    end
  end

  assign step_rs1       = rs1_q;
  assign step_acc       = acc_q;
  assign step_arg_0     = arg_0_q;
  assign step_count     = count_q;
  assign step_carryless = clmul_q;
  assign step_pw        = pw_q;
  assign rsp_rd         = rd_q;

  // A well-behaved step only reports done once count reaches the lane width
  a_ready_at_width: assert property (@(posedge g_clk) disable iff (g_reset)
    (state == ST_RUN && step_ready) |-> (count_q == pw_width));

endmodule
